// File: rtl/mul_seq_pkg.sv
// Shared widths, FSM state type and step-to-shift helper for the iterative 8x8 multiplier.
package mul_seq_pkg;

    localparam int unsigned STEP_W = 2;
    localparam int unsigned NIB_W  = 4;
    localparam int unsigned OP_W   = 8;
    localparam int unsigned P_W    = 16;
    localparam int unsigned SH_W   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    // Shift applied to a nibble product: 4*(k[1]+k[0]); the 2-bit sum sits above two zero bits.
    function automatic logic [SH_W-1:0] shift_amt(input logic [STEP_W-1:0] step);
        return {step[1] & step[0], step[1] ^ step[0], 2'b00};
    endfunction

endpackage

// File: rtl/multiplier_4bits_version12.sv
// 4x4 unsigned combinational multiplier core, time-shared by the sequential 8x8 wrapper.
module multiplier_4bits_version12
    import mul_seq_pkg::*;
(
    input  logic [NIB_W-1:0] a_i,
    input  logic [NIB_W-1:0] b_i,
    output logic [OP_W-1:0]  p_o
);

    // Zero-extend both nibbles so the product is formed at full 8-bit width.
    assign p_o = {4'b0000, a_i} * {4'b0000, b_i};

endmodule

// File: rtl/multiplier_8bits_seq_4x4.sv
// Iterative 8x8 unsigned multiplier: four nibble-pair products from one 4x4 core, shift-added
// into a 16-bit accumulator, with valid/ready handshakes on operands and result.
module multiplier_8bits_seq_4x4
    import mul_seq_pkg::*;
#(
    parameter bit REG_CORE_OUT = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OP_W-1:0] in_a,
    input  logic [OP_W-1:0] in_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [P_W-1:0]  out_p,
    output logic            busy
);

    state_e              state_q, state_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic                iss_done_q, iss_done_d;
    logic [OP_W-1:0]     a_q, a_d;
    logic [OP_W-1:0]     b_q, b_d;
    logic [P_W-1:0]      acc_q, acc_d;
    logic                out_valid_q, out_valid_d;
    logic                busy_q, busy_d;

    logic [NIB_W-1:0]    a_nib, b_nib;
    logic [OP_W-1:0]     core_p;
    logic                issue;
    logic                accept;
    logic                add_en;
    logic [OP_W-1:0]     add_prod;
    logic [STEP_W-1:0]   add_step;

    // Operand handshake: ready in IDLE, or in DONE when the result is being taken this cycle.
    assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign out_p     = acc_q;
    assign busy      = busy_q;

    // A new nibble pair is fed to the core each CALC cycle until all four have been issued.
    assign issue = (state_q == CALC) && !iss_done_q;

    // Nibble muxes: step bit 1 selects the a nibble, step bit 0 the b nibble.
    assign a_nib = step_q[1] ? a_q[7:4] : a_q[3:0];
    assign b_nib = step_q[0] ? b_q[7:4] : b_q[3:0];

    multiplier_4bits_version12 u_core (
        .a_i (a_nib),
        .b_i (b_nib),
        .p_o (core_p)
    );

    generate
        if (REG_CORE_OUT) begin : g_core_reg
            logic [OP_W-1:0]   prod_q;
            logic [STEP_W-1:0] pstep_q;
            logic              pv_q;

            // Pipeline the core product and its step tag; the add happens one edge later.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    prod_q  <= '0;
                    pstep_q <= '0;
                    pv_q    <= 1'b0;
                end else begin
                    prod_q  <= core_p;
                    pstep_q <= step_q;
                    pv_q    <= issue;
                end
            end

            assign add_en   = pv_q;
            assign add_prod = prod_q;
            assign add_step = pstep_q;
        end else begin : g_core_comb
            assign add_en   = issue;
            assign add_prod = core_p;
            assign add_step = step_q;
        end
    endgenerate

    // Next-state, accumulate and handshake logic.
    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        iss_done_d  = iss_done_q;
        a_d         = a_q;
        b_d         = b_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q;

        if (add_en) begin
            acc_d = acc_q + (P_W'(add_prod) << shift_amt(add_step));
        end

        if (issue) begin
            step_d = step_q + STEP_W'(1);
            if (step_q == STEP_W'(3)) begin
                iss_done_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: ;
            CALC: begin
                if (add_en && (add_step == STEP_W'(3))) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Accept (from IDLE or back-to-back from DONE) overrides: latch operands, restart.
        if (accept) begin
            state_d     = CALC;
            step_d      = '0;
            iss_done_d  = 1'b0;
            a_d         = in_a;
            b_d         = in_b;
            acc_d       = '0;
            out_valid_d = 1'b0;
        end

        busy_d = (state_d == CALC);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            step_q      <= '0;
            iss_done_q  <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            iss_done_q  <= iss_done_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

endmodule

// File: tb/tb_multiplier_8bits_seq_4x4.sv
// Directed and randomized checks of the sequential 8x8 multiplier, both core-output variants.
module tb_multiplier_8bits_seq_4x4;

    logic        clk;
    logic        rst_n;

    logic        iv0, ir0, ov0, or0, busy0;
    logic [7:0]  a0, b0;
    logic [15:0] p0;

    logic        iv1, ir1, ov1, or1, busy1;
    logic [7:0]  a1, b1;
    logic [15:0] p1;

    int total;
    int bad;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] p;
        int          hold;
    } vec_t;

    multiplier_8bits_seq_4x4 #(.REG_CORE_OUT(1'b0)) dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (iv0),
        .in_ready  (ir0),
        .in_a      (a0),
        .in_b      (b0),
        .out_valid (ov0),
        .out_ready (or0),
        .out_p     (p0),
        .busy      (busy0)
    );

    multiplier_8bits_seq_4x4 #(.REG_CORE_OUT(1'b1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (iv1),
        .in_ready  (ir1),
        .in_a      (a1),
        .in_b      (b1),
        .out_valid (ov1),
        .out_ready (or1),
        .out_p     (p1),
        .busy      (busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // One op on the REG_CORE_OUT=0 instance; hold>0 keeps out_ready low that many DONE cycles.
    task automatic run_op0(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp,
                           input int hold);
        int edges;
        int bc;
        @(negedge clk);
        iv0 = 1'b1;
        a0  = a;
        b0  = b;
        or0 = (hold == 0);
        #1;
        check("idle_in_ready", 32'(ir0), 32'd1);
        @(posedge clk);
        @(negedge clk);
        iv0 = (hold > 0);
        a0  = ~a;
        b0  = ~b;
        edges = 0;
        bc    = 0;
        while (!ov0 && edges < 20) begin
            if (busy0) bc++;
            check("calc_in_ready", 32'(ir0), 32'd0);
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        check("latency", 32'(edges), 32'd4);
        check("busy_cycles", 32'(bc), 32'd4);
        check("product", 32'(p0), 32'(exp));
        check("done_in_ready", 32'(ir0), (hold == 0) ? 32'd1 : 32'd0);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            @(negedge clk);
            check("stall_valid", 32'(ov0), 32'd1);
            check("stall_product", 32'(p0), 32'(exp));
            check("stall_in_ready", 32'(ir0), 32'd0);
        end
        iv0 = 1'b0;
        or0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("valid_drop", 32'(ov0), 32'd0);
        check("busy_after", 32'(busy0), 32'd0);
    endtask

    initial begin
        vec_t        vecs[10];
        int          edges;
        int          bc;
        int          w;
        int          k;
        bit          pend;
        logic [7:0]  ra, rb;
        logic [15:0] rexp;

        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        iv0 = 1'b0; a0 = '0; b0 = '0; or0 = 1'b1;
        iv1 = 1'b0; a1 = '0; b1 = '0; or1 = 1'b0;

        vecs[0] = '{8'h12, 8'h34, 16'h03A8, 0};
        vecs[1] = '{8'hFF, 8'hFF, 16'hFE01, 0};
        vecs[2] = '{8'h00, 8'h5A, 16'h0000, 0};
        vecs[3] = '{8'hA5, 8'h3C, 16'h26AC, 10};
        vecs[4] = '{8'h0F, 8'hF0, 16'h0E10, 0};
        vecs[5] = '{8'hF0, 8'hF0, 16'hE100, 2};
        vecs[6] = '{8'h80, 8'h02, 16'h0100, 0};
        vecs[7] = '{8'h01, 8'hFF, 16'h00FF, 0};
        vecs[8] = '{8'hFF, 8'h01, 16'h00FF, 1};
        vecs[9] = '{8'h5A, 8'h00, 16'h0000, 0};

        repeat (2) @(negedge clk);
        check("rst_valid0", 32'(ov0), 32'd0);
        check("rst_p0", 32'(p0), 32'd0);
        check("rst_busy0", 32'(busy0), 32'd0);
        check("rst_ready0", 32'(ir0), 32'd1);
        check("rst_valid1", 32'(ov1), 32'd0);
        check("rst_p1", 32'(p1), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_op0(vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].hold);
        end

        // Back-to-back: second op accepted on the DONE handshake edge with no idle cycle.
        @(negedge clk);
        iv0 = 1'b1; a0 = 8'h0F; b0 = 8'h0F; or0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a0 = 8'h10; b0 = 8'h10;
        edges = 0;
        while (!ov0 && edges < 20) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        check("b2b_lat1", 32'(edges), 32'd4);
        check("b2b_p1", 32'(p0), 32'h00E1);
        check("b2b_ready", 32'(ir0), 32'd1);
        @(posedge clk);
        @(negedge clk);
        iv0 = 1'b0; a0 = 8'hEE; b0 = 8'hEE;
        check("b2b_valid_low", 32'(ov0), 32'd0);
        check("b2b_no_idle", 32'(busy0), 32'd1);
        edges = 0;
        bc    = 0;
        while (!ov0 && edges < 20) begin
            if (busy0) bc++;
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        check("b2b_lat2", 32'(edges), 32'd4);
        check("b2b_busy2", 32'(bc), 32'd4);
        check("b2b_p2", 32'(p0), 32'h0100);
        @(posedge clk);
        @(negedge clk);
        check("b2b_done", 32'(ov0), 32'd0);

        // Reset in the middle of CALC, after step 2 has accumulated.
        @(negedge clk);
        iv0 = 1'b1; a0 = 8'h12; b0 = 8'h34; or0 = 1'b1;
        @(posedge clk);
        #1;
        iv0 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("pre_rst_busy", 32'(busy0), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(ov0), 32'd0);
        check("mid_rst_busy", 32'(busy0), 32'd0);
        check("mid_rst_p", 32'(p0), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post_rst_valid", 32'(ov0), 32'd0);
        end
        run_op0(8'h03, 8'h07, 16'h0015, 0);

        // Randomized regression on the registered-core instance with back-pressure.
        pend = 1'b0;
        @(negedge clk);
        for (int n = 0; n < 1000; n++) begin
            ra   = 8'($urandom);
            rb   = 8'($urandom);
            rexp = {8'h00, ra} * {8'h00, rb};
            iv1 = 1'b1; a1 = ra; b1 = rb; or1 = pend;
            #1;
            w = 0;
            while (!ir1 && w < 10) begin
                @(posedge clk);
                @(negedge clk);
                w++;
            end
            check("r_in_ready", 32'(ir1), 32'd1);
            @(posedge clk);
            pend = 1'b0;
            @(negedge clk);
            iv1 = 1'b0; a1 = ~ra; b1 = ~rb;
            edges = 0;
            while (!ov1 && edges < 20) begin
                or1 = 1'($urandom);
                @(posedge clk);
                edges++;
                @(negedge clk);
            end
            or1 = 1'b0;
            check("r_latency", 32'(edges), 32'd5);
            check("r_product", 32'(p1), 32'(rexp));
            k = int'($urandom_range(0, 3));
            for (int s = 0; s < k; s++) begin
                @(posedge clk);
                @(negedge clk);
                check("r_stall_p", 32'(p1), 32'(rexp));
                check("r_stall_v", 32'(ov1), 32'd1);
            end
            if (n < 999 && $urandom_range(0, 1) == 1) begin
                pend = 1'b1;
            end else begin
                or1 = 1'b1;
                @(posedge clk);
                @(negedge clk);
                or1 = 1'b0;
                check("r_valid_drop", 32'(ov1), 32'd0);
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
